psa_search_scheduler: RTL and testbench
=======================================

// Module: psa_search_scheduler
// PURPOSE
//  Shares one pattern-search engine (pattern BRAM + data BRAM comparator) between NREQ requesters.
//  Accepts search jobs (p, pl, b, bl) and grants them round-robin. For each job it pulses the engine
//  reset, holds activate until the engine reports done, and routes found/timeout back to the requester.
//  Sits between the host/UART command layer and the search engine.
// PARAMETERS
//  NREQ     2     number of requesters (1..4); request buses are flattened, requester i at [8*i+7:8*i]
//  TIMEOUT  4096  RUN-state cycle budget per job before abort (max 65535)
// PORTS
//  CLK100MHZ     in   1       system clock
//  reset         in   1       asynchronous, active-high reset
//  req_valid     in   NREQ    requester i has a job pending; p/pl/b/bl held stable until req_ready[i]
//  req_p         in   8*NREQ  pattern BRAM start address per requester
//  req_pl        in   8*NREQ  pattern length per requester
//  req_b         in   8*NREQ  data BRAM block start address per requester
//  req_bl        in   8*NREQ  block length per requester
//  req_ready     out  NREQ    one-cycle accept pulse, one-hot
//  resp_valid    out  NREQ    one-cycle result pulse, one-hot, to the requester that owned the job
//  resp_found    out  8       engine found value (8'hFF = not found / error / timeout), valid with resp_valid
//  resp_err      out  1       job rejected without running, valid with resp_valid
//  resp_timeout  out  1       job aborted at TIMEOUT, valid with resp_valid
//  busy          out  1       high from accept until resp_valid inclusive
//  eng_p         out  8       to engine p
//  eng_pl        out  8       to engine pl
//  eng_b         out  8       to engine b
//  eng_bl        out  8       to engine bl
//  eng_reset     out  1       to engine reset (engine resets on its posedge)
//  eng_activate  out  1       to engine activate
//  eng_done      in   1       engine done (sticky until the engine is reset)
//  eng_found     in   8       engine found
// BEHAVIOUR
//  Reset values: req_ready=0, resp_valid=0, resp_found=8'hFF, resp_err=0, resp_timeout=0, busy=0,
//   eng_p/pl/b/bl=0, eng_activate=0, eng_reset=1 (engine held reset). All outputs registered.
//  FSM: IDLE -> LOAD -> ENG_RST -> RUN -> RESP -> IDLE; IDLE -> RESP directly on a rejected job.
//  IDLE: eng_reset=0, eng_activate=0. If any req_valid: grant first set bit searching upward (wrapping)
//   from last_grant+1; last_grant resets to NREQ-1, so requester 0 wins first. Pulse req_ready[g] and
//   latch its fields into eng_* and the owner register. Set busy.
//  Reject if pl==0, bl==0, pl>bl, or 9-bit {1'b0,b}+bl > 256: go to RESP with resp_err=1 and
//   resp_found=8'hFF. The engine is not touched.
//  LOAD: 1 cycle, eng_* settle. ENG_RST: eng_reset=1 for exactly 1 cycle.
//  RUN: eng_reset=0, eng_activate=1, and a 16-bit cycle counter increments from 0.
//   When eng_done=1 is sampled: latch eng_found, drop eng_activate, go to RESP.
//   When the counter reaches TIMEOUT-1 with eng_done=0: resp_timeout=1, resp_found=8'hFF, drop
//   eng_activate, assert eng_reset, go to RESP.
//   If eng_done and the timeout fall on the same cycle, done wins (no timeout).
//  RESP: resp_valid[owner] for 1 cycle, with resp_found, resp_err and resp_timeout.
//   Next cycle: IDLE, busy=0, resp_err and resp_timeout cleared, last_grant=owner.
//   The earliest new grant is the cycle after that.
//  Latency for a valid job: accept (IDLE) -> LOAD -> ENG_RST -> first RUN cycle is 3 cycles;
//   resp_valid is 1 cycle after eng_done is first sampled high.
//  req_valid dropped by a requester after acceptance: the job still completes and responds.
//  req_valid toggling during a job has no effect; one job is in flight at a time; no queueing.
//  Async reset mid-job: immediate return to IDLE with reset values (eng_reset=1, activate=0).
//   The in-flight job is lost and gets no response.
// TESTING
//  1 Single job, req 0: p=0, pl=3, b=10, bl=20; engine model done at RUN cycle 40 with found=8'h0E
//    -> req_ready[0] 1 pulse, eng_reset 1 pulse, resp_valid[0] with found=8'h0E, err=0, timeout=0.
//  2 Both req_valid high from reset -> grant order 0,1,0,1; each req_ready one-hot; no overlap of busy.
//  3 Rejects: pl=0; pl=5 with bl=4; b=8'hF0 with bl=8'h20 -> resp_err=1, found=8'hFF,
//    eng_reset never pulsed, resp 2 cycles after accept.
//  4 Engine never asserts done, TIMEOUT=16 -> resp_timeout=1, found=8'hFF, eng_reset=1 on abort.
//  5 eng_done first high on counter=TIMEOUT-1 -> eng_found returned, resp_timeout=0.
//  6 Async reset 5 cycles into RUN -> outputs at reset values same cycle; no resp_valid;
//    next job runs normally and requester 0 has priority.

Source files
------------

// File: rtl/psa_search_scheduler_if.sv
// Requester and engine signal bundle for psa_search_scheduler.
// The scheduler uses the slave view; the environment uses the master view.
interface psa_search_scheduler_if #(
  parameter int unsigned NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_p;
  logic [8*NREQ-1:0] req_pl;
  logic [8*NREQ-1:0] req_b;
  logic [8*NREQ-1:0] req_bl;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   resp_valid;
  logic [7:0]        resp_found;
  logic              resp_err;
  logic              resp_timeout;
  logic              busy;
  logic [7:0]        eng_p;
  logic [7:0]        eng_pl;
  logic [7:0]        eng_b;
  logic [7:0]        eng_bl;
  logic              eng_reset;
  logic              eng_activate;
  logic              eng_done;
  logic [7:0]        eng_found;

  modport slave (
    input  req_valid, req_p, req_pl, req_b, req_bl, eng_done, eng_found,
    output req_ready, resp_valid, resp_found, resp_err, resp_timeout, busy,
           eng_p, eng_pl, eng_b, eng_bl, eng_reset, eng_activate
  );

  modport master (
    output req_valid, req_p, req_pl, req_b, req_bl, eng_done, eng_found,
    input  req_ready, resp_valid, resp_found, resp_err, resp_timeout, busy,
           eng_p, eng_pl, eng_b, eng_bl, eng_reset, eng_activate
  );
endinterface

// File: rtl/psa_search_scheduler.sv
// Round-robin scheduler sharing one pattern-search engine between NREQ requesters.
// Validates each job, sequences engine reset/activate, enforces a cycle budget, routes the result.
module psa_search_scheduler #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 4096
) (
  input logic                   CLK100MHZ,
  input logic                   reset,
  psa_search_scheduler_if.slave bus
);
  localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ENG_RST, S_RUN, S_RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic [NREQ-1:0]   r_req_ready, w_req_ready_nxt;
  logic [NREQ-1:0]   r_resp_valid, w_resp_valid_nxt;
  logic [7:0]        r_resp_found, w_resp_found_nxt;
  logic              r_resp_err, w_resp_err_nxt;
  logic              r_resp_timeout, w_resp_timeout_nxt;
  logic              r_busy, w_busy_nxt;
  logic [7:0]        r_eng_p, w_eng_p_nxt;
  logic [7:0]        r_eng_pl, w_eng_pl_nxt;
  logic [7:0]        r_eng_b, w_eng_b_nxt;
  logic [7:0]        r_eng_bl, w_eng_bl_nxt;
  logic              r_eng_reset, w_eng_reset_nxt;
  logic              r_eng_activate, w_eng_activate_nxt;
  logic [GW-1:0]     r_owner, w_owner_nxt;
  logic [GW-1:0]     r_last_grant, w_last_grant_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;

  logic              w_any;
  logic [GW-1:0]     w_grant;
  logic [7:0]        w_p, w_pl, w_b, w_bl;
  logic [8:0]        w_end;
  logic              w_bad;

  // Round-robin pick: first pending requester above the last grant, wrapping
  always_comb begin
    w_any   = 1'b0;
    w_grant = r_last_grant;
    for (int k = 1; k <= int'(NREQ); k++) begin
      if (!w_any && bus.req_valid[(int'(r_last_grant) + k) % int'(NREQ)]) begin
        w_any   = 1'b1;
        w_grant = GW'((int'(r_last_grant) + k) % int'(NREQ));
      end
    end
  end

  assign w_p   = bus.req_p [8*int'(w_grant) +: 8];
  assign w_pl  = bus.req_pl[8*int'(w_grant) +: 8];
  assign w_b   = bus.req_b [8*int'(w_grant) +: 8];
  assign w_bl  = bus.req_bl[8*int'(w_grant) +: 8];
  assign w_end = {1'b0, w_b} + {1'b0, w_bl};
  assign w_bad = (w_pl == 8'd0) || (w_bl == 8'd0) || (w_pl > w_bl) || (w_end > 9'd256);

  always_comb begin
    w_state_nxt        = r_state;
    w_req_ready_nxt    = '0;
    w_resp_valid_nxt   = '0;
    w_resp_found_nxt   = r_resp_found;
    w_resp_err_nxt     = r_resp_err;
    w_resp_timeout_nxt = r_resp_timeout;
    w_busy_nxt         = r_busy;
    w_eng_p_nxt        = r_eng_p;
    w_eng_pl_nxt       = r_eng_pl;
    w_eng_b_nxt        = r_eng_b;
    w_eng_bl_nxt       = r_eng_bl;
    w_eng_reset_nxt    = r_eng_reset;
    w_eng_activate_nxt = r_eng_activate;
    w_owner_nxt        = r_owner;
    w_last_grant_nxt   = r_last_grant;
    w_cnt_nxt          = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_eng_reset_nxt    = 1'b0;
        w_eng_activate_nxt = 1'b0;
        if (w_any) begin
          w_req_ready_nxt = NREQ'(1) << w_grant;
          w_owner_nxt     = w_grant;
          w_busy_nxt      = 1'b1;
          if (w_bad) begin
            w_state_nxt = S_RESP;
          end else begin
            w_eng_p_nxt  = w_p;
            w_eng_pl_nxt = w_pl;
            w_eng_b_nxt  = w_b;
            w_eng_bl_nxt = w_bl;
            w_state_nxt  = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        w_eng_reset_nxt = 1'b1;
        w_state_nxt     = S_ENG_RST;
      end
      S_ENG_RST: begin
        w_eng_reset_nxt    = 1'b0;
        w_eng_activate_nxt = 1'b1;
        w_cnt_nxt          = '0;
        w_state_nxt        = S_RUN;
      end
      S_RUN: begin
        w_cnt_nxt = r_cnt + CW'(1);
        // done takes precedence over a coincident budget expiry
        if (bus.eng_done) begin
          w_resp_found_nxt   = bus.eng_found;
          w_eng_activate_nxt = 1'b0;
          w_resp_valid_nxt   = NREQ'(1) << r_owner;
          w_state_nxt        = S_RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_resp_timeout_nxt = 1'b1;
          w_resp_found_nxt   = 8'hFF;
          w_eng_activate_nxt = 1'b0;
          w_eng_reset_nxt    = 1'b1;
          w_resp_valid_nxt   = NREQ'(1) << r_owner;
          w_state_nxt        = S_RESP;
        end
      end
      S_RESP: begin
        // A rejected job arrives here with no response issued yet
        if (r_resp_valid == '0) begin
          w_resp_valid_nxt = NREQ'(1) << r_owner;
          w_resp_err_nxt   = 1'b1;
          w_resp_found_nxt = 8'hFF;
        end else begin
          w_busy_nxt         = 1'b0;
          w_resp_err_nxt     = 1'b0;
          w_resp_timeout_nxt = 1'b0;
          w_eng_reset_nxt    = 1'b0;
          w_last_grant_nxt   = r_owner;
          w_state_nxt        = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_req_ready    <= '0;
      r_resp_valid   <= '0;
      r_resp_found   <= 8'hFF;
      r_resp_err     <= 1'b0;
      r_resp_timeout <= 1'b0;
      r_busy         <= 1'b0;
      r_eng_p        <= '0;
      r_eng_pl       <= '0;
      r_eng_b        <= '0;
      r_eng_bl       <= '0;
      r_eng_reset    <= 1'b1;
      r_eng_activate <= 1'b0;
      r_owner        <= '0;
      r_last_grant   <= GW'(NREQ - 1);
      r_cnt          <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_req_ready    <= w_req_ready_nxt;
      r_resp_valid   <= w_resp_valid_nxt;
      r_resp_found   <= w_resp_found_nxt;
      r_resp_err     <= w_resp_err_nxt;
      r_resp_timeout <= w_resp_timeout_nxt;
      r_busy         <= w_busy_nxt;
      r_eng_p        <= w_eng_p_nxt;
      r_eng_pl       <= w_eng_pl_nxt;
      r_eng_b        <= w_eng_b_nxt;
      r_eng_bl       <= w_eng_bl_nxt;
      r_eng_reset    <= w_eng_reset_nxt;
      r_eng_activate <= w_eng_activate_nxt;
      r_owner        <= w_owner_nxt;
      r_last_grant   <= w_last_grant_nxt;
      r_cnt          <= w_cnt_nxt;
    end
  end

  assign bus.req_ready    = r_req_ready;
  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_found   = r_resp_found;
  assign bus.resp_err     = r_resp_err;
  assign bus.resp_timeout = r_resp_timeout;
  assign bus.busy         = r_busy;
  assign bus.eng_p        = r_eng_p;
  assign bus.eng_pl       = r_eng_pl;
  assign bus.eng_b        = r_eng_b;
  assign bus.eng_bl       = r_eng_bl;
  assign bus.eng_reset    = r_eng_reset;
  assign bus.eng_activate = r_eng_activate;
endmodule

// File: tb/tb_psa_search_scheduler.sv
// Directed bench for psa_search_scheduler: one instance at TIMEOUT=4096, one at TIMEOUT=16,
// sharing stimulus through a selector and a single behavioural engine model.
module tb_psa_search_scheduler;
  localparam int unsigned NREQ = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  psa_search_scheduler_if #(.NREQ(NREQ)) bus_a ();
  psa_search_scheduler_if #(.NREQ(NREQ)) bus_b ();

  psa_search_scheduler #(.NREQ(NREQ), .TIMEOUT(4096)) dut_a (.CLK100MHZ(clk), .reset(rst), .bus(bus_a));
  psa_search_scheduler #(.NREQ(NREQ), .TIMEOUT(16))   dut_b (.CLK100MHZ(clk), .reset(rst), .bus(bus_b));

  logic              sel = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_p = '0, req_pl = '0, req_b = '0, req_bl = '0;
  logic [7:0]        eng_found_v = 8'h00;
  logic              m_done = 1'b0;
  int                m_run = 0;
  int                done_at = 1000;

  assign bus_a.req_valid = sel ? '0 : req_valid;
  assign bus_b.req_valid = sel ? req_valid : '0;
  assign bus_a.req_p  = req_p;  assign bus_b.req_p  = req_p;
  assign bus_a.req_pl = req_pl; assign bus_b.req_pl = req_pl;
  assign bus_a.req_b  = req_b;  assign bus_b.req_b  = req_b;
  assign bus_a.req_bl = req_bl; assign bus_b.req_bl = req_bl;
  assign bus_a.eng_found = eng_found_v;
  assign bus_b.eng_found = eng_found_v;
  assign bus_a.eng_done  = sel ? 1'b0 : m_done;
  assign bus_b.eng_done  = sel ? m_done : 1'b0;

  logic [NREQ-1:0] o_req_ready, o_resp_valid;
  logic [7:0]      o_resp_found, o_eng_p, o_eng_pl, o_eng_b, o_eng_bl;
  logic            o_resp_err, o_resp_timeout, o_busy, o_eng_reset, o_eng_activate;
  assign o_req_ready    = sel ? bus_b.req_ready    : bus_a.req_ready;
  assign o_resp_valid   = sel ? bus_b.resp_valid   : bus_a.resp_valid;
  assign o_resp_found   = sel ? bus_b.resp_found   : bus_a.resp_found;
  assign o_resp_err     = sel ? bus_b.resp_err     : bus_a.resp_err;
  assign o_resp_timeout = sel ? bus_b.resp_timeout : bus_a.resp_timeout;
  assign o_busy         = sel ? bus_b.busy         : bus_a.busy;
  assign o_eng_p        = sel ? bus_b.eng_p        : bus_a.eng_p;
  assign o_eng_pl       = sel ? bus_b.eng_pl       : bus_a.eng_pl;
  assign o_eng_b        = sel ? bus_b.eng_b        : bus_a.eng_b;
  assign o_eng_bl       = sel ? bus_b.eng_bl       : bus_a.eng_bl;
  assign o_eng_reset    = sel ? bus_b.eng_reset    : bus_a.eng_reset;
  assign o_eng_activate = sel ? bus_b.eng_activate : bus_a.eng_activate;

  // Engine model: done rises on active cycle number done_at and sticks until reset
  always @(negedge clk) begin
    if (o_eng_reset) begin
      m_run  = 0;
      m_done = 1'b0;
    end else if (o_eng_activate) begin
      if (m_run >= done_at) m_done = 1'b1;
      m_run++;
    end
  end

  int   mon_rise = 0, mon_hi = 0, mon_resp = 0, mon_viol = 0;
  logic prev_rst = 1'b1;
  always @(negedge clk) begin
    if (o_eng_reset && !prev_rst) mon_rise++;
    if (o_eng_reset) mon_hi++;
    prev_rst = o_eng_reset;
    if (o_resp_valid != '0) mon_resp++;
    if (!$onehot0(bus_a.req_ready) || !$onehot0(bus_a.resp_valid) ||
        !$onehot0(bus_b.req_ready) || !$onehot0(bus_b.resp_valid)) mon_viol++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic [7:0] p, input logic [7:0] pl,
                         input logic [7:0] b, input logic [7:0] bl);
    req_p [8*r +: 8] = p;
    req_pl[8*r +: 8] = pl;
    req_b [8*r +: 8] = b;
    req_bl[8*r +: 8] = bl;
  endtask

  // Raise vmask, wait for the accept, then wait for the response; all waits bounded
  task automatic job(input logic [NREQ-1:0] vmask, input logic hold, input int d_at,
                     input logic [7:0] found_i,
                     output logic [NREQ-1:0] rdy, output logic [NREQ-1:0] rv,
                     output logic [7:0] rf, output logic re, output logic rt, output int lat,
                     output logic busy_resp, output logic busy_after, output logic ers_resp);
    done_at = d_at;
    eng_found_v = found_i;
    req_valid = vmask;
    rdy = '0; rv = '0; rf = 8'h00; re = 1'bx; rt = 1'bx; lat = -1;
    busy_resp = 1'bx; busy_after = 1'bx; ers_resp = 1'bx;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (o_req_ready != '0) begin rdy = o_req_ready; break; end
    end
    if (!hold) req_valid = '0;
    if (rdy != '0) begin
      for (int c = 1; c < 300; c++) begin
        @(negedge clk);
        if (o_resp_valid != '0) begin
          rv = o_resp_valid; rf = o_resp_found; re = o_resp_err; rt = o_resp_timeout;
          lat = c; busy_resp = o_busy; ers_resp = o_eng_reset;
          break;
        end
      end
      @(negedge clk);
      busy_after = o_busy;
    end
  endtask

  logic [NREQ-1:0] rdy, rv;
  logic [7:0]      rf;
  logic            re, rt, busy_resp, busy_after, ers_resp;
  int              lat, base_rise, base_hi, base_resp;

  initial begin
    repeat (3) @(negedge clk);
    check("rst req_ready", 32'(o_req_ready), 32'h0);
    check("rst resp_valid", 32'(o_resp_valid), 32'h0);
    check("rst resp_found", 32'(o_resp_found), 32'hFF);
    check("rst resp_err", 32'(o_resp_err), 32'h0);
    check("rst resp_timeout", 32'(o_resp_timeout), 32'h0);
    check("rst busy", 32'(o_busy), 32'h0);
    check("rst eng_fields", 32'({o_eng_p, o_eng_pl, o_eng_b, o_eng_bl}), 32'h0);
    check("rst eng_reset", 32'(o_eng_reset), 32'h1);
    check("rst eng_activate", 32'(o_eng_activate), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle eng_reset", 32'(o_eng_reset), 32'h0);

    // Both requesters pending: alternate starting with requester 0
    set_req(0, 8'h00, 8'h03, 8'h0A, 8'h14);
    set_req(1, 8'h04, 8'h02, 8'h32, 8'h0A);
    for (int j = 0; j < 4; j++) begin
      job(2'b11, 1'b1, 2, 8'h21, rdy, rv, rf, re, rt, lat, busy_resp, busy_after, ers_resp);
      check($sformatf("rr grant %0d", j), 32'(rdy), (j % 2 == 0) ? 32'h1 : 32'h2);
      check($sformatf("rr resp %0d", j), 32'(rv), (j % 2 == 0) ? 32'h1 : 32'h2);
      check($sformatf("rr busy_drop %0d", j), 32'(busy_after), 32'h0);
    end
    req_valid = '0;
    repeat (2) @(negedge clk);

    // Single valid job on requester 0, done on run cycle 40
    base_rise = mon_rise; base_hi = mon_hi;
    job(2'b01, 1'b0, 40, 8'h0E, rdy, rv, rf, re, rt, lat, busy_resp, busy_after, ers_resp);
    check("t1 ready", 32'(rdy), 32'h1);
    check("t1 eng_p_pl_b_bl", 32'({o_eng_p, o_eng_pl, o_eng_b, o_eng_bl}), 32'h00030A14);
    check("t1 resp_valid", 32'(rv), 32'h1);
    check("t1 found", 32'(rf), 32'h0E);
    check("t1 err", 32'(re), 32'h0);
    check("t1 timeout", 32'(rt), 32'h0);
    check("t1 latency", 32'(lat), 32'd43);
    check("t1 busy_at_resp", 32'(busy_resp), 32'h1);
    check("t1 busy_after", 32'(busy_after), 32'h0);
    check("t1 eng_reset rises", 32'(mon_rise - base_rise), 32'd1);
    check("t1 eng_reset cycles", 32'(mon_hi - base_hi), 32'd1);

    // Rejected jobs never touch the engine and respond one cycle after the accept pulse
    for (int j = 0; j < 3; j++) begin
      case (j)
        0:       set_req(0, 8'h00, 8'h00, 8'h10, 8'h04);
        1:       set_req(0, 8'h00, 8'h05, 8'h10, 8'h04);
        default: set_req(0, 8'h00, 8'h01, 8'hF0, 8'h20);
      endcase
      base_rise = mon_rise;
      job(2'b01, 1'b0, 2, 8'h33, rdy, rv, rf, re, rt, lat, busy_resp, busy_after, ers_resp);
      check($sformatf("rej%0d resp_valid", j), 32'(rv), 32'h1);
      check($sformatf("rej%0d err", j), 32'(re), 32'h1);
      check($sformatf("rej%0d found", j), 32'(rf), 32'hFF);
      check($sformatf("rej%0d latency", j), 32'(lat), 32'd1);
      check($sformatf("rej%0d eng_reset rises", j), 32'(mon_rise - base_rise), 32'd0);
    end
    // Block ending exactly at address 256 is legal
    set_req(0, 8'h00, 8'h01, 8'hE0, 8'h20);
    job(2'b01, 1'b0, 2, 8'h44, rdy, rv, rf, re, rt, lat, busy_resp, busy_after, ers_resp);
    check("edge256 err", 32'(re), 32'h0);
    check("edge256 found", 32'(rf), 32'h44);
    check("edge256 latency", 32'(lat), 32'd5);

    // TIMEOUT=16 instance: no done aborts on counter 15
    sel = 1'b1;
    set_req(0, 8'h00, 8'h03, 8'h0A, 8'h14);
    repeat (2) @(negedge clk);
    base_rise = mon_rise;
    job(2'b01, 1'b0, 1000, 8'h55, rdy, rv, rf, re, rt, lat, busy_resp, busy_after, ers_resp);
    check("to resp_valid", 32'(rv), 32'h1);
    check("to timeout", 32'(rt), 32'h1);
    check("to found", 32'(rf), 32'hFF);
    check("to err", 32'(re), 32'h0);
    check("to latency", 32'(lat), 32'd18);
    check("to eng_reset_on_abort", 32'(ers_resp), 32'h1);
    check("to eng_reset rises", 32'(mon_rise - base_rise), 32'd2);

    // Done on the very last budget cycle wins over the timeout
    job(2'b01, 1'b0, 15, 8'h5A, rdy, rv, rf, re, rt, lat, busy_resp, busy_after, ers_resp);
    check("lastcyc timeout", 32'(rt), 32'h0);
    check("lastcyc found", 32'(rf), 32'h5A);
    check("lastcyc latency", 32'(lat), 32'd18);
    sel = 1'b0;
    repeat (2) @(negedge clk);

    // Async reset during RUN drops the job without a response
    set_req(0, 8'h00, 8'h03, 8'h0A, 8'h14);
    done_at = 40;
    req_valid = 2'b01;
    rdy = '0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (o_req_ready != '0) begin rdy = o_req_ready; break; end
    end
    req_valid = '0;
    check("ar ready", 32'(rdy), 32'h1);
    repeat (7) @(negedge clk);
    check("ar running", 32'(o_eng_activate), 32'h1);
    base_resp = mon_resp;
    #2 rst = 1'b1;
    #1;
    check("ar busy", 32'(o_busy), 32'h0);
    check("ar eng_reset", 32'(o_eng_reset), 32'h1);
    check("ar eng_activate", 32'(o_eng_activate), 32'h0);
    check("ar resp_found", 32'(o_resp_found), 32'hFF);
    check("ar eng_fields", 32'({o_eng_p, o_eng_pl, o_eng_b, o_eng_bl}), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("ar no response", 32'(mon_resp - base_resp), 32'd0);
    job(2'b11, 1'b0, 3, 8'h66, rdy, rv, rf, re, rt, lat, busy_resp, busy_after, ers_resp);
    check("ar regrant req0", 32'(rdy), 32'h1);
    check("ar rerun resp", 32'(rv), 32'h1);
    check("ar rerun found", 32'(rf), 32'h66);
    check("ar rerun latency", 32'(lat), 32'd6);
    check("onehot violations", 32'(mon_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
